// File: rtl/btn_pulse_gen_pkg.sv
// btn_pkg: shared constants for the push-button conditioning block.
//   BTN_*            bit positions of each button in btn_raw/btn_pulse/btn_level
//   *_DEF            default timing (cycles of the 1 kHz tick clock)
//   max2()           elaboration helper for sizing counters
package btn_pkg;
    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;

    localparam int N_BTN_DEF         = 5;
    localparam int DEB_CYCLES_DEF    = 20;
    localparam int REPEAT_DELAY_DEF  = 500;
    localparam int REPEAT_PERIOD_DEF = 100;
    localparam logic [N_BTN_DEF-1:0] REPEAT_EN_DEF = 5'b11110;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/btn_pulse_gen_if.sv
// btn_pulse_gen_if: button bundle between the raw pins and the consumers.
//   btn_raw   : raw asynchronous button levels (1 = pressed)
//   btn_pulse : one-cycle press / auto-repeat pulses
//   btn_level : debounced held level
// master drives btn_raw and observes the outputs; slave is the conditioner.
interface btn_pulse_gen_if
    import btn_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_level;

    modport master (output btn_raw, input btn_pulse, input btn_level);
    modport slave  (input btn_raw, output btn_pulse, output btn_level);
endinterface

// File: rtl/btn_pulse_gen_channel.sv
// btn_channel: one button's conditioning chain.
//   clk, rst_n : tick clock, async active-low reset
//   raw        : asynchronous bouncy level
//   pulse      : registered one-cycle press / repeat pulse
//   level      : registered debounced level
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter bit repeat_en     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int HCW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic           s1, s2, db, rpt;
    logic [DCW-1:0] dcnt;
    logic [HCW-1:0] hcnt;
    logic           accept, rise, rpt_fire;

    // s2 has differed from db for DEB_CYCLES consecutive samples
    assign accept = (s2 != db) && (dcnt == DCW'(DEB_CYCLES - 1));
    assign rise   = accept && s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            dcnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                dcnt <= '0;
            end else if (accept) begin
                db   <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    generate
        if (repeat_en) begin : g_rpt
            // First terminal is the initial delay, then the repeat period
            assign rpt_fire = db && (rpt ? (hcnt == HCW'(REPEAT_PERIOD - 1))
                                         : (hcnt == HCW'(REPEAT_DELAY - 1)));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt <= '0;
                    rpt  <= 1'b0;
                end else if (!db) begin
                    hcnt <= '0;
                    rpt  <= 1'b0;
                end else if (rpt_fire) begin
                    hcnt <= '0;
                    rpt  <= 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
            assign hcnt     = '0;
            assign rpt      = 1'b0;
        end
    endgenerate

    // Registered on the same edge db rises, so pulse and level align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse <= 1'b0;
        else        pulse <= rise || rpt_fire;
    end

    assign level = db;
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: conditions N_BTN raw push-buttons into clean press pulses.
//   clk   : 1 kHz tick clock shared with the state controller
//   rst_n : async active-low reset
//   bus   : btn_raw in, btn_pulse / btn_level out (slave side)
// Each button is an independent btn_channel; no cross-button priority.
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int               N_BTN         = N_BTN_DEF,
    parameter int               DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int               REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int               REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter logic [N_BTN-1:0] REPEAT_EN     = REPEAT_EN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_pulse_gen_if.slave bus
);
    logic [N_BTN-1:0] pulse_w;
    logic [N_BTN-1:0] level_w;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_channel #(
                .DEB_CYCLES   (DEB_CYCLES),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD),
                .repeat_en    (REPEAT_EN[gi])
            ) u_ch (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (bus.btn_raw[gi]),
                .pulse(pulse_w[gi]),
                .level(level_w[gi])
            );
        end
    endgenerate

    assign bus.btn_pulse = pulse_w;
    assign bus.btn_level = level_w;
endmodule

// File: tb/tb_btn_pulse_gen.sv
module tb_btn_pulse_gen;
    import btn_pkg::*;

    typedef struct {
        int         cyc;
        logic [4:0] mask;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_n = 0;
    int   vecs   = 0;
    int   errs   = 0;
    ev_t  q[$];

    btn_pulse_gen_if #(.N_BTN(5)) bus ();

    btn_pulse_gen dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Scoreboard: every nonzero pulse or expected event is compared
    logic [4:0] exp_p;
    always @(negedge clk) begin
        exp_p = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == edge_n) begin
                exp_p = exp_p | q[i].mask;
                q.delete(i);
            end
        end
        if (exp_p != '0 || bus.btn_pulse != '0) begin
            vecs++;
            assert (bus.btn_pulse === exp_p) else begin
                errs++;
                $error("FAIL pulse@edge%0d: got %b expected %b", edge_n, bus.btn_pulse, exp_p);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int cyc, input logic [4:0] mask);
        ev_t e;
        e.cyc  = cyc;
        e.mask = mask;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s@edge%0d: got %b expected %b", tag, edge_n, obs, expv);
        end
    endtask

    int k;

    initial begin
        // Reset held with every button pressed
        rst_n       = 1'b0;
        bus.btn_raw = 5'b11111;
        #2;
        chk("rst_level0", bus.btn_level, 5'b00000);
        chk("rst_pulse0", bus.btn_pulse, 5'b00000);
        tick(3);
        chk("rst_level1", bus.btn_level, 5'b00000);
        chk("rst_pulse1", bus.btn_pulse, 5'b00000);
        rst_n = 1'b1;
        k = edge_n;
        push(k + 22, 5'b11111);
        tick(21);
        chk("post_rst_lvl21", bus.btn_level, 5'b00000);
        tick(1);
        chk("post_rst_lvl22", bus.btn_level, 5'b11111);
        bus.btn_raw = 5'b00000;
        tick(21);
        chk("rel_lvl21", bus.btn_level, 5'b11111);
        tick(1);
        chk("rel_lvl22", bus.btn_level, 5'b00000);
        tick(10);

        // Bounce on C: 5-cycle segments, then a clean hold of 800 cycles
        for (int s = 0; s < 12; s++) begin
            bus.btn_raw[BTN_C] = (s % 2 == 0);
            tick(5);
        end
        chk("bounce_lvl", bus.btn_level, 5'b00000);
        bus.btn_raw[BTN_C] = 1'b1;
        k = edge_n;
        push(k + 22, 5'b00001);
        tick(21);
        chk("c_lvl21", bus.btn_level, 5'b00000);
        tick(1);
        chk("c_lvl22", bus.btn_level, 5'b00001);
        tick(800 - 22);
        bus.btn_raw[BTN_C] = 1'b0;
        tick(22);
        chk("c_rel", bus.btn_level, 5'b00000);
        tick(10);

        // Glitch on L: 19 cycles rejected, 20 cycles accepted
        bus.btn_raw[BTN_L] = 1'b1;
        tick(19);
        bus.btn_raw[BTN_L] = 1'b0;
        tick(40);
        chk("glitch19_lvl", bus.btn_level, 5'b00000);
        bus.btn_raw[BTN_L] = 1'b1;
        k = edge_n;
        push(k + 22, 5'b00010);
        tick(20);
        bus.btn_raw[BTN_L] = 1'b0;
        tick(1);
        chk("glitch20_lvl21", bus.btn_level, 5'b00000);
        tick(1);
        chk("glitch20_lvl22", bus.btn_level, 5'b00010);
        tick(30);
        chk("glitch20_rel", bus.btn_level, 5'b00000);

        // Auto-repeat on L
        bus.btn_raw[BTN_L] = 1'b1;
        k = edge_n;
        push(k + 22, 5'b00010);
        push(k + 522, 5'b00010);
        push(k + 622, 5'b00010);
        push(k + 722, 5'b00010);
        tick(780);
        chk("rpt_lvl", bus.btn_level, 5'b00010);
        bus.btn_raw[BTN_L] = 1'b0;
        tick(150);
        chk("rpt_rel", bus.btn_level, 5'b00000);

        // U and D together, then async reset on the first repeat pulse
        bus.btn_raw = 5'b11000;
        k = edge_n;
        push(k + 22, 5'b11000);
        push(k + 522, 5'b11000);
        tick(22);
        chk("ud_lvl", bus.btn_level, 5'b11000);
        tick(500);
        chk("ud_rpt_pulse", bus.btn_pulse, 5'b11000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_pulse", bus.btn_pulse, 5'b00000);
        chk("async_level", bus.btn_level, 5'b00000);
        tick(3);
        rst_n = 1'b1;
        k = edge_n;
        push(k + 22, 5'b11000);
        tick(21);
        chk("rerst_lvl21", bus.btn_level, 5'b00000);
        tick(1);
        chk("rerst_lvl22", bus.btn_level, 5'b11000);
        bus.btn_raw = 5'b00000;
        tick(30);
        chk("final_lvl", bus.btn_level, 5'b00000);

        // Any expected pulse never seen is a miss
        vecs++;
        assert (q.size() == 0) else begin
            errs++;
            $error("FAIL missed_pulses: got %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
